// File: rtl/proc_pkg.sv
// Shared constants for the lab processor control unit: opcodes, step codes
// and instruction field positions (instruction format IIIXXXYYY).
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  // Debug view of the step: {halt, step}; HALT only exists with the trap build.
  localparam logic [2:0] DBG_HALT = 3'b100;

  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int RX_HI = 5;
  localparam int RX_LO = 3;
  localparam int RY_HI = 2;
  localparam int RY_LO = 0;

endpackage

// File: rtl/proc_step_cnt.sv
// 2-bit time-step counter: synchronous clear wins over increment.
module proc_step_cnt
  import proc_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       clr,
  input  logic       inc,
  output logic [1:0] step
);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)  step <= T0;
    else if (clr) step <= T0;
    else if (inc) step <= step + 2'd1;
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Instruction sequencer T0..T3 with Moore control strobes for the lab processor.
// Optional macro PROC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes set sticky Err and halt.
module proc_ctrl_fsm
  import proc_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Run,
  input  logic [8:0] DIN,
  output logic [8:0] IR,
  output logic [2:0] Rin_sel,
  output logic       Rin_en,
  output logic [2:0] Rout_sel,
  output logic       Rout_en,
  output logic       DINout,
  output logic       Gout,
  output logic       Ain,
  output logic       Gin,
  output logic       AddSub,
  output logic       IRin,
  output logic       Done,
  output logic       Err,
  output logic [2:0] dbg_step
);

  // Handshake: Run is a level request, sampled only in T0 when not halted;
  // IRin marks the accepting cycle and IR loads on that clock edge.
  logic [1:0] step;
  logic       halt;
  logic       trap;
  logic       clr;
  logic       inc;
  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       is_addsub;
  logic       is_legal;

  assign op        = IR[OP_HI:OP_LO];
  assign rx        = IR[RX_HI:RX_LO];
  assign ry        = IR[RY_HI:RY_LO];
  assign is_addsub = (op == OP_ADD) || (op == OP_SUB);
  assign is_legal  = (op == OP_MV) || (op == OP_MVI) || is_addsub;

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
  assign trap = (step == T1) && !is_legal;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      halt <= 1'b0;
      Err  <= 1'b0;
    end else if (trap) begin
      halt <= 1'b1;
      Err  <= 1'b1;
    end
  end
`else
  assign trap = 1'b0;
  assign halt = 1'b0;
  assign Err  = 1'b0;
`endif

  always_comb begin
    Rin_sel  = 3'd0;
    Rin_en   = 1'b0;
    Rout_sel = 3'd0;
    Rout_en  = 1'b0;
    DINout   = 1'b0;
    Gout     = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    AddSub   = 1'b0;
    IRin     = 1'b0;
    Done     = 1'b0;
    case (step)
      // Gated by Resetn so every strobe reads 0 while reset is held.
      T0: IRin = Run && !halt && Resetn;
      T1: begin
        if (op == OP_MV) begin
          Rout_sel = ry;
          Rout_en  = 1'b1;
          Rin_sel  = rx;
          Rin_en   = 1'b1;
          Done     = 1'b1;
        end else if (op == OP_MVI) begin
          DINout  = 1'b1;
          Rin_sel = rx;
          Rin_en  = 1'b1;
          Done    = 1'b1;
        end else if (is_addsub) begin
          Rout_sel = rx;
          Rout_en  = 1'b1;
          Ain      = 1'b1;
        end else begin
          Done = !trap;
        end
      end
      T2: begin
        Rout_sel = ry;
        Rout_en  = 1'b1;
        Gin      = 1'b1;
        AddSub   = op[0];
      end
      T3: begin
        Gout    = 1'b1;
        Rin_sel = rx;
        Rin_en  = 1'b1;
        Done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign clr = Done || trap;
  assign inc = IRin || ((step == T1) && is_addsub) || (step == T2);

  proc_step_cnt u_step_cnt (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (clr),
    .inc    (inc),
    .step   (step)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)   IR <= 9'd0;
    else if (IRin) IR <= DIN;
  end

  assign dbg_step = halt ? DBG_HALT : {1'b0, step};

endmodule

// File: doc/proc_ctrl_fsm.md
# proc_ctrl_fsm

Instruction-sequencing control unit for the lab simple processor. It latches a 9-bit instruction word from the DIN bus, steps through time-steps T0–T3, and emits per-step control strobes. Its 3-bit register-select codes with enables feed directly into the `dec3to8` decoders that generate the one-hot register-file write and read enables. It sits between the instruction/data bus and the datapath's register decoders, ALU and bus mux.

## Interface
- No parameters. Widths are fixed at a 9-bit instruction and 8 registers.
- Clock  in  1  single system clock, rising edge.
- Resetn  in  1  reset; asynchronous, active-low.
- Run  in  1  start request, sampled only in T0.
- DIN  in  9  instruction/data bus; instruction format IIIXXXYYY (opcode[8:6], Rx[5:3], Ry[2:0]).
- IR  out  9  latched instruction register.
- Rin_sel  out  3  destination register code, to write-enable `dec3to8` W.
- Rin_en  out  1  write enable, to write-enable `dec3to8` En.
- Rout_sel  out  3  source register code, to bus-select `dec3to8` W.
- Rout_en  out  1  source-register bus drive, to bus-select `dec3to8` En.
- DINout  out  1  DIN drives the bus.
- Gout  out  1  G register drives the bus.
- Ain  out  1  load the A register.
- Gin  out  1  load the G register.
- AddSub  out  1  ALU operation: 0 = add, 1 = sub.
- IRin  out  1  IR load strobe (informational; IR is held internally).
- Done  out  1  instruction completes this cycle.
- Err  out  1  illegal opcode flag (only with the macro; see Configuration).

## Operation
- Opcodes:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#D
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 100–111 are illegal.
- States: T0 (fetch/idle), T1, T2, T3. The state is held in a 2-bit step register.
- T0:
  - Run=0: stay in T0; all strobes are 0.
  - Run=1: IRin=1, IR<=DIN on the clock edge, next state T1.
- T1:
  - mv: Rout_sel=Y, Rout_en=1, Rin_sel=X, Rin_en=1, Done=1, next T0.
  - mvi: DINout=1, Rin_sel=X, Rin_en=1, Done=1, next T0. The immediate must be on DIN during this cycle.
  - add/sub: Rout_sel=X, Rout_en=1, Ain=1, next T2.
  - illegal: Done=1, next T0 (the instruction behaves as a NOP).
- T2 (add/sub): Rout_sel=Y, Rout_en=1, Gin=1, AddSub=opcode[0], next T3.
- T3 (add/sub): Gout=1, Rin_sel=X, Rin_en=1, Done=1, next T0.
- Rin_sel and Rout_sel are 0 whenever their enable is 0.
- Bus exclusivity: at most one of Rout_en, DINout, Gout is 1 in any cycle. The bench asserts this.
- Run outside T0 is ignored. There is no abort and no re-latch of IR.
- Run held high: a new instruction is fetched in the T0 that immediately follows Done, giving back-to-back execution.

## Timing
- Outputs are Moore-style: a combinational decode of the step register and IR, valid throughout the cycle.
- Latency, counted from the T0 edge with Run=1:
  - mv, mvi: 2 cycles.
  - add, sub: 4 cycles.
- Reset (Resetn=0):
  - Takes effect immediately, asynchronously, including mid-instruction.
  - Step register goes to T0 and IR goes to 0; all outputs are 0.
  - An aborted instruction does not assert Done.
- After Resetn deasserts, the first Run sample is on the next rising edge.
- Simultaneous Run=1 and Done: cannot occur, because Run is only sampled in T0 and Done is never asserted in T0.

## Configuration
- PROC_CTRL_ILLEGAL_TRAP_EN
  - Defined:
    - In T1, an illegal opcode sets sticky Err=1 and the FSM enters a HALT state.
    - HALT asserts no strobes and no Done, and ignores Run.
    - HALT is exited only by reset, which clears Err.
  - Undefined:
    - Illegal opcodes execute as a 2-cycle NOP with Done.
    - The Err port exists but is tied to 0.

## Structure
- Shared package proc_pkg:
  - Opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB.
  - Step encoding T0–T3 plus HALT.
  - Instruction field index constants.
- Sub-module proc_step_cnt:
  - 2-bit step counter with synchronous clear (on Done) and increment enable.
  - Async active-low reset, same Clock/Resetn.
- The FSM decode and the IR register stay in proc_ctrl_fsm.

## Test plan
- Reset mid-add:
  - Stimulus: DIN=9'b010_001_010, Run=1; assert Resetn=0 during T2.
  - Required: all outputs go to 0 immediately, IR=0, no Done; the next instruction runs normally.
- mv R3,R5:
  - Stimulus: DIN=9'b000_011_101, Run pulse.
  - Required: in T1, Rout_sel=5, Rout_en=1, Rin_sel=3, Rin_en=1, Done=1; the following cycle is T0.
- mvi R7,#0x0AA:
  - Stimulus: instruction 9'b001_111_000, then DIN=9'h0AA.
  - Required: in T1, DINout=1, Rin_sel=7, Rin_en=1, Done=1.
- sub R1,R2:
  - Required step sequence:
    - T1: Rout_sel=1, Ain=1.
    - T2: Rout_sel=2, Gin=1, AddSub=1.
    - T3: Gout=1, Rin_sel=1, Done=1.
  - Exactly 4 cycles.
- Back-to-back:
  - Stimulus: Run held high with add followed by mv.
  - Required: the second IR latches in the T0 right after the first Done.
  - Run asserted during T2 has no effect.
  - Bus-exclusivity assertion never fires.
- Illegal opcode 9'b110_000_000:
  - Macro undefined: Done in T1, Err=0.
  - Macro defined: Err=1 stays set and the FSM is halted, ignoring Run, until Resetn=0.
